// File: rtl/muldiv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_arbiter                                                  |
// | Function : round-robin share of one sequential mul/div unit between two    |
// |            valid/ready requesters; result is routed back to the issuer.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module muldiv_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             unit_req_valid,
  input  logic             unit_req_ready,
  output logic [OPW-1:0]   unit_op,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic             unit_resp_valid,
  output logic             unit_resp_ready,
  input  logic [WIDTH-1:0] unit_resp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_owner;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_unit_req_valid;
  logic             r_unit_resp_ready;
  logic             r_resp0_valid;
  logic             r_resp1_valid;
  logic             r_busy;

  logic             w_grant_valid;
  logic             w_grant;
  logic             w_resp_fire;

  // The pointer only breaks ties; a lone requester is granted at once.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = r_prio;
      end else if (req0_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b0;
      end else if (req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant       = 1'b1;
      end
    end
  end

  assign req0_ready  = w_grant_valid && !w_grant;
  assign req1_ready  = w_grant_valid &&  w_grant;
  assign w_resp_fire = r_owner ? (r_resp1_valid && resp1_ready)
                               : (r_resp0_valid && resp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_prio            <= 1'b0;
      r_owner           <= 1'b0;
      r_op              <= '0;
      r_a               <= '0;
      r_b               <= '0;
      r_resp_data       <= '0;
      r_unit_req_valid  <= 1'b0;
      r_unit_resp_ready <= 1'b0;
      r_resp0_valid     <= 1'b0;
      r_resp1_valid     <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A grant implies the granted valid is high, so the grant is the fire.
          if (w_grant_valid) begin
            r_owner          <= w_grant;
            r_op             <= w_grant ? req1_op : req0_op;
            r_a              <= w_grant ? req1_a  : req0_a;
            r_b              <= w_grant ? req1_b  : req0_b;
            r_unit_req_valid <= 1'b1;
            r_busy           <= 1'b1;
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (unit_req_ready) begin
            r_unit_req_valid  <= 1'b0;
            r_unit_resp_ready <= 1'b1;
            r_state           <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (unit_resp_valid) begin
            r_resp_data       <= unit_resp_data;
            r_unit_resp_ready <= 1'b0;
            r_resp0_valid     <= !r_owner;
            r_resp1_valid     <=  r_owner;
            r_state           <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_fire) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_prio        <= ~r_owner;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign unit_req_valid  = r_unit_req_valid;
  assign unit_resp_ready = r_unit_resp_ready;
  assign unit_op         = r_op;
  assign unit_a          = r_a;
  assign unit_b          = r_b;
  assign resp0_valid     = r_resp0_valid;
  assign resp1_valid     = r_resp1_valid;
  assign resp_data       = r_resp_data;
  assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_arbiter                                               |
// | Function : directed scoreboard bench for muldiv_arbiter with a unit model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_muldiv_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam logic [OPW-1:0] OP_MUL = 4'd0;
  localparam logic [OPW-1:0] OP_DIV = 4'd4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0] req0_op, req1_op, unit_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, unit_a, unit_b;
  logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [WIDTH-1:0] resp_data, unit_resp_data;
  logic unit_req_valid, unit_req_ready, unit_resp_valid, unit_resp_ready, busy;

  muldiv_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data),
    .unit_req_valid(unit_req_valid), .unit_req_ready(unit_req_ready),
    .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready),
    .unit_resp_data(unit_resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             side;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  bit   grant_log[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input bit side, input logic [WIDTH-1:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    sb.push_back(e);
  endtask

  // Unit model: multiplies or divides, with configurable issue stall and latency.
  int req_stall = 0;
  int lat       = 5;
  int u_st      = 0;
  int u_cnt     = 0;
  int u_stall   = 0;
  bit u_rdy     = 1'b0;
  logic [WIDTH-1:0] u_res;

  function automatic logic [WIDTH-1:0] unit_calc(input logic [OPW-1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    if (op == OP_MUL) return a * b;
    if (op == OP_DIV) return (b == '0) ? '1 : a / b;
    return '0;
  endfunction

  initial begin
    unit_req_ready  = 1'b0;
    unit_resp_valid = 1'b0;
    unit_resp_data  = '0;
    u_res           = '0;
  end

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      u_st = 0; u_stall = 0;
      unit_req_ready = 1'b0; unit_resp_valid = 1'b0;
    end else begin
      case (u_st)
        0: if (unit_req_valid) begin
             if (u_stall >= req_stall) begin
               unit_req_ready = 1'b1;
               u_res = unit_calc(unit_op, unit_a, unit_b);
               u_st = 1;
             end else u_stall++;
           end
        1: begin unit_req_ready = 1'b0; u_stall = 0; u_cnt = 1; u_st = 2; end
        2: if (u_cnt >= lat) begin
             unit_resp_valid = 1'b1; unit_resp_data = u_res;
             u_rdy = unit_resp_ready; u_st = 3;
           end else u_cnt++;
        default: if (u_rdy) begin unit_resp_valid = 1'b0; u_st = 0; end
                 else u_rdy = unit_resp_ready;
      endcase
    end
  end

  // Response monitor: pops the scoreboard on each response fire.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready))) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got side %0d data %0h expected none", resp1_valid, resp_data);
      end else begin
        e = sb.pop_front();
        if ((resp0_valid && resp1_valid) || resp1_valid !== e.side || resp_data !== e.data) begin
          fails++;
          $display("FAIL resp: got v0=%0d v1=%0d data %0h expected side %0d data %0h",
                   resp0_valid, resp1_valid, resp_data, e.side, e.data);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the fire.
  task automatic issue(input bit side, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, output int waited);
    if (!side) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else       begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    waited = 0;
    forever begin
      #1;
      if (side ? req1_ready : req0_ready) begin
        grant_log.push_back(side);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        tests++; fails++;
        $display("FAIL issue_timeout: got no accept on side %0d expected accept", side);
        break;
      end
    end
    if (!side) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic check_grants(input string name, input bit exp_seq[$]);
    check({name, "_count"}, grant_log.size(), exp_seq.size());
    foreach (exp_seq[i])
      if (i < grant_log.size()) check(name, grant_log[i], exp_seq[i]);
    grant_log.delete();
  endtask

  initial begin
    int w, w0, w1, n;
    bit stable;
    logic [WIDTH-1:0] d_snap;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valids", {unit_req_valid, unit_resp_ready, resp0_valid, resp1_valid}, 0);
    check("rst_payload", {unit_op, unit_a, unit_b} == '0, 1);
    check("rst_resp_data", resp_data, 0);
    check("rst_req_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);

    // 1: single request
    expect_resp(0, 42);
    issue(0, OP_MUL, 6, 7, w);
    check("t1_busy_after_accept", busy, 1);
    check("t1_unit_req_valid", unit_req_valid, 1);
    drain("t1");
    check("t1_busy_after_resp", busy, 0);
    grant_log.delete();

    // 2: simultaneous requests after reset, req0 first
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    expect_resp(0, 14);
    expect_resp(1, 27);
    fork
      issue(0, OP_DIV, 100, 7, w0);
      issue(1, OP_MUL, 9, 3, w1);
    join
    drain("t2");
    check_grants("t2_grant", '{1'b0, 1'b1});

    // 3: continuous contention alternates grants
    expect_resp(0, 12);  expect_resp(1, 100);
    expect_resp(0, 25);  expect_resp(1, 10);
    expect_resp(0, 9);   expect_resp(1, 56);
    fork
      begin
        int wa;
        issue(0, OP_MUL, 3, 4, wa);
        issue(0, OP_MUL, 5, 5, wa);
        issue(0, OP_DIV, 81, 9, wa);
      end
      begin
        int wb;
        issue(1, OP_MUL, 10, 10, wb);
        issue(1, OP_DIV, 50, 5, wb);
        issue(1, OP_MUL, 7, 8, wb);
      end
    join
    drain("t3");
    check_grants("t3_grant", '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});

    // 4: backpressure on unit issue and on response
    req_stall = 4;
    resp1_ready = 1'b0;
    expect_resp(1, 100);
    expect_resp(0, 121);
    issue(1, OP_DIV, 1000, 10, w);
    req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 11; req0_b = 11;
    check("t4_unit_payload", {unit_op, unit_a, unit_b}, {OP_DIV, 32'd1000, 32'd10});
    stable = 1'b1;
    n = 0;
    while (!resp1_valid && n < 50) begin
      #1;
      if ({unit_op, unit_a, unit_b} !== {OP_DIV, 32'd1000, 32'd10} || req0_ready) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check("t4_payload_stable_no_accept", stable, 1);
    check("t4_resp1_valid", resp1_valid, 1);
    d_snap = resp_data;
    check("t4_resp_data", d_snap, 100);
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (!resp1_valid || resp0_valid || resp_data !== d_snap || req0_ready) stable = 1'b0;
    end
    check("t4_resp_hold", stable, 1);
    @(negedge clk);
    resp1_ready = 1'b1;
    req_stall = 0;
    issue(0, OP_MUL, 11, 11, w);
    check("t4_req0_waited", w, 1);
    drain("t4");
    grant_log.delete();

    // 5: reset during S_WAIT discards the operation; prio was 1 before reset
    issue(0, OP_MUL, 5, 5, w);
    n = 0;
    while (!unit_resp_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reached_wait", unit_resp_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valids", {resp0_valid, resp1_valid, unit_req_valid, unit_resp_ready}, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_prio_reset", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    expect_resp(1, 32'hFFFF_FFFF);
    issue(1, OP_MUL, 32'hFFFF_FFFF, 1, w);
    drain("t5");
    grant_log.delete();

    // 6: lone req1 with prio=0 granted without delay
    expect_resp(1, 144);
    issue(1, OP_MUL, 12, 12, w);
    check("t6_no_wait", w, 0);
    drain("t6");
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one sequential multiply/divide unit between two requesters, e.g. the ALU of two execution lanes, or an ALU plus a CSR/debug path.
- Arbitrates round-robin and issues one operation at a time to the unit.
- Captures the unit's result and routes it back to the requester that issued the operation.
- Sits between the requesters' stage handshakes and the multiplier/divider's in/out handshakes. All ports use valid/ready; a transfer fires when both are high on a rising clk edge.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 4, opcode width; passed through to the unit unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_op  in  OPW  requester 0 opcode.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1.
- resp0_valid  out  1  result available for requester 0.
- resp0_ready  in  1  requester 0 takes its result.
- resp1_valid  out  1  result available for requester 1.
- resp1_ready  in  1  requester 1 takes its result.
- resp_data  out  WIDTH  result; shared by both response ports.
- unit_req_valid  out  1  issue to the unit.
- unit_req_ready  in  1  unit accepts the issue.
- unit_op  out  OPW  latched opcode.
- unit_a  out  WIDTH  latched operand A.
- unit_b  out  WIDTH  latched operand B.
- unit_resp_valid  in  1  unit result valid.
- unit_resp_ready  out  1  arbiter takes the unit result.
- unit_resp_data  in  WIDTH  unit result.
- busy  out  1  state is not S_IDLE.

Behaviour:
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP. Only one operation is in flight at any time.
- S_IDLE grant rule (combinational):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the side selected by the 1-bit priority pointer `prio`.
  - Neither high: no grant.
- S_IDLE ready: reqN_ready=1 only for the granted side; the other side's ready stays 0. Ready may depend on the valids; the valids must not depend on ready.
- On a requester fire:
  - Latch op, a and b into unit_op/unit_a/unit_b.
  - Latch `owner`, the granted side.
  - Go to S_ISSUE.
- S_ISSUE: unit_req_valid=1. On unit_req_ready go to S_WAIT. The latched payload holds stable until the fire.
- S_WAIT: unit_resp_ready=1. On unit_resp_valid, latch unit_resp_data into resp_data and go to S_RESP.
- S_RESP:
  - resp<owner>_valid=1; the other response valid stays 0.
  - On resp<owner>_ready go to S_IDLE and set prio = ~owner.
- Priority pointer: updates only at response completion, never on accept or on an ungranted cycle. This guarantees no starvation under continuous dual requests.
- Latency: requester fire at cycle N.
  - unit_req_valid high at N+1.
  - resp valid at one cycle after the unit_resp fire.
  - Minimum accept-to-response is 3 cycles plus the unit's compute time.
- Back-to-back: a new request cannot be accepted in the same cycle the response fires; the earliest accept is the next cycle, in S_IDLE.
- Output register hold rules:
  - resp_data holds until the next unit result is latched.
  - unit_op/unit_a/unit_b hold until the next accept.
- Reset values:
  - state S_IDLE, prio=0, owner=0.
  - All latched payloads 0; resp_data 0.
  - All valid/ready outputs 0 except reqN_ready, which follows the grant rule.
  - busy=0.
- Reset mid-operation: any in-flight operation is discarded and no response is produced. The unit shares rst and is reset with the arbiter.
- A requester dropping valid before its fire is legal and not an error; arbitration re-evaluates every cycle in S_IDLE.
- Unit handshake protocol errors are not detected; the unit is trusted.

Test Plan:
1. Single request: req0 op=MUL a=6 b=7, unit returns 42 after 5 cycles -> resp0_valid with resp_data=42; resp1_valid never asserts; busy=1 from accept until resp fire.
2. Simultaneous requests after reset: req0 (a=100 b=7) and req1 (a=9 b=3) both valid -> req0 served first (prio=0), then req1 accepted the cycle after resp0 fires, result routed only on resp1.
3. Continuous contention: both valid for 6 operations -> grants alternate 0,1,0,1,0,1; no side is granted twice in a row.
4. Backpressure: hold unit_req_ready=0 for 4 cycles, then resp1_ready=0 for 3 cycles -> unit_op/a/b stable throughout; resp1_valid and resp_data stable until ready; no new accept while blocked.
5. Reset mid-operation: assert rst during S_WAIT -> next cycle busy=0, all resp valids 0, prio=0; a following req1 (a=0xFFFFFFFF b=1) completes normally with the unit's result.
6. Only req1 valid while prio=0 -> req1 granted immediately, with no idle cycle spent waiting for req0.
